// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and line levels.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Start bit + payload + one stop bit.
  localparam int unsigned FRAME_BITS    = UART_DATA_WIDTH + 2;
  localparam logic        TX_IDLE_LEVEL = 1'b1;

  function automatic int unsigned frame_bits(input int unsigned data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: flags the last clock of each bit. Shared with the future RX stage.
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] baud_cnt;

  assign bit_end = (baud_cnt == div_q - DIV_WIDTH'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt <= '0;
    end else if (restart || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter draining the TX FIFO read port; back-to-back frames have no idle gap.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic                  bit_end;
  logic                  load;
  logic                  restart;

  assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;

  // A new frame may start from idle or on the final clock of a stop bit.
  assign load = resetn && enable && !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign fifo_pop = load;

  // Counter is held at zero while idle so the first bit of a frame is full length.
  assign restart = load || (state == ST_IDLE);

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_tick (
    .clk    (clk),
    .resetn (resetn),
    .restart(restart),
    .div_q  (div_q),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      tx      <= TX_IDLE_LEVEL;
      busy    <= 1'b0;
      shift_q <= '0;
      bit_cnt <= '0;
      div_q   <= DIV_WIDTH'(1);
    end else if (load) begin
      state   <= ST_START;
      tx      <= ~TX_IDLE_LEVEL;
      busy    <= 1'b1;
      shift_q <= fifo_dout;
      bit_cnt <= '0;
      div_q   <= div_eff;
    end else if (bit_end) begin
      case (state)
        ST_START: begin
          state <= ST_DATA;
          tx    <= shift_q[0];
        end
        ST_DATA: begin
          shift_q <= shift_q >> 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state <= ST_STOP;
            tx    <= TX_IDLE_LEVEL;
          end else begin
            tx <= shift_q[1];
          end
        end
        ST_STOP: begin
          state <= ST_IDLE;
          tx    <= TX_IDLE_LEVEL;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench for uart_tx_fifo_drain: stimulus queues expected frames, a monitor checks the line.
module tb_uart_tx_fifo_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 16;

  typedef struct {
    logic [7:0] data;
    int         dv;
  } exp_t;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [VW-1:0] div    = '0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          tx;
  logic          busy;

  logic [7:0] mem [16];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;

  exp_t exp_q[$];
  int   pop_log[$];
  int   cyc      = 0;
  bit   mon_busy = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  uart_tx_fifo_drain #(
    .DATA_WIDTH(DW),
    .DIV_WIDTH (VW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div       (div),
    .enable    (enable),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Small FIFO model: stimulus writes, the DUT pop strobe advances the read pointer.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr];
  always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 4'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input int dv);
    exp_q.push_back('{data: d, dv: dv});
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= max_cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: still waiting after %0d cycles, %0d frames left", n, exp_q.size());
    end
  endtask

  // Monitor: every pop starts a frame; checks each line cycle against the queued byte.
  initial begin : monitor
    bit   pending;
    bit   aborted;
    bit   last;
    logic lvl;
    exp_t cur;
    pending = 1'b0;
    forever begin
      if (!pending) begin
        do @(negedge clk); while (fifo_pop !== 1'b1);
      end
      pending  = 1'b0;
      mon_busy = 1'b1;
      aborted  = 1'b0;
      pop_log.push_back(cyc);
      check("pop_while_empty", 32'(fifo_empty), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
        cur.data = 8'h00;
        cur.dv   = 1;
      end else begin
        cur = exp_q.pop_front();
      end
      for (int b = 0; b < 10; b++) begin
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur.data[3'(b - 1)];
        for (int k = 0; k < cur.dv; k++) begin
          @(negedge clk);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
          check($sformatf("tx_bit%0d_byte%02h", b, cur.data), 32'(tx), 32'(lvl));
          check("busy_in_frame", 32'(busy), 32'd1);
          last = (b == 9) && (k == cur.dv - 1);
          if (last) pending = fifo_pop;
          else if (fifo_pop) check("early_pop", 32'd1, 32'd0);
        end
        if (aborted) break;
      end
      if (aborted) begin
        pending = 1'b0;
      end else if (!pending) begin
        @(negedge clk);
        if (resetn) check("busy_after_frame", 32'(busy), 32'd0);
        pending = fifo_pop;
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : stimulus
    bit pop_seen;
    bit tx_low;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    enable = 1'b1;

    // Empty FIFO after reset: line stays idle
    pop_seen = 1'b0;
    tx_low   = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_pop) pop_seen = 1'b1;
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    check("idle_no_pop", 32'(pop_seen), 32'd0);
    check("idle_tx_high", 32'(tx_low), 32'd0);

    // Single byte 0xA5 at 4 clocks per bit
    @(posedge clk); #1;
    pop_log.delete();
    div = 16'd4;
    push(8'hA5, 4);
    wait_drain(200);
    check("a5_pop_count", 32'(pop_log.size()), 32'd1);

    // Back-to-back 0x55, 0x0F at 3 clocks per bit
    pop_log.delete();
    div = 16'd3;
    push(8'h55, 3);
    push(8'h0F, 3);
    wait_drain(200);
    check("b2b_pop_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2) check("b2b_pop_spacing", 32'(pop_log[1] - pop_log[0]), 32'd30);

    // div=0 behaves as 1
    pop_log.delete();
    div = 16'd0;
    push(8'hFF, 1);
    wait_drain(100);
    check("div0_pop_count", 32'(pop_log.size()), 32'd1);

    // Mid-frame div change and enable drop with a second byte queued
    pop_log.delete();
    div = 16'd4;
    push(8'h3C, 4);
    push(8'hC3, 8);
    repeat (10) @(posedge clk);
    #1;
    div    = 16'd8;
    enable = 1'b0;
    pop_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (fifo_pop) pop_seen = 1'b1;
    end
    check("disabled_no_pop", 32'(pop_seen), 32'd0);
    check("disabled_pop_count", 32'(pop_log.size()), 32'd1);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_drain(300);
    check("reenable_pop_count", 32'(pop_log.size()), 32'd2);

    // Reset during data bit 3 of 0x96 (bit 3 is low), then a clean frame
    pop_log.delete();
    div = 16'd4;
    push(8'h96, 4);
    n = 0;
    while (pop_log.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_case_popped", 32'(pop_log.size()), 32'd1);
    repeat (17) @(posedge clk);
    #2;
    check("tx_before_reset", 32'(tx), 32'd0);
    resetn = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    pop_log.delete();
    push(8'h5A, 4);
    wait_drain(200);
    check("post_rst_pop_count", 32'(pop_log.size()), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
